// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and predictor counter type.
// Contents: primary opcodes for conditional branches, REGIMM rt selectors,
// and the 2-bit saturating counter type with its four named states.
package mips_pkg;

  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t SNT = 2'b00;
  localparam bht_cnt_t WNT = 2'b01;
  localparam bht_cnt_t WT  = 2'b10;
  localparam bht_cnt_t ST  = 2'b11;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/result handshake bundle for branch_resolve_unit.
// req_*: decode -> unit (valid/ready), res_*: unit -> fetch redirect (valid/ready).
// master: decode/consumer side, slave: the resolve unit.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [5:0]      req_opcode;
  logic [4:0]      req_rt;
  logic [XLEN-1:0] req_rs_val;
  logic [XLEN-1:0] req_rt_val;
  logic [XLEN-1:0] req_pc;
  logic [15:0]     req_imm;
  logic            req_pred_taken;

  logic            res_valid;
  logic            res_ready;
  logic            res_is_branch;
  logic            res_taken;
  logic [XLEN-1:0] res_next_pc;
  logic            res_mispredict;

  modport master (
    output req_valid, req_opcode, req_rt, req_rs_val, req_rt_val, req_pc,
           req_imm, req_pred_taken, res_ready,
    input  req_ready, res_valid, res_is_branch, res_taken, res_next_pc,
           res_mispredict
  );

  modport slave (
    input  req_valid, req_opcode, req_rt, req_rs_val, req_rt_val, req_pc,
           req_imm, req_pred_taken, res_ready,
    output req_ready, res_valid, res_is_branch, res_taken, res_next_pc,
           res_mispredict
  );
endinterface

// File: rtl/branch_resolve_unit_cond.sv
// branch_cond_eval: combinational branch recogniser and condition evaluator.
// Ports: opcode/rt select the branch kind, rs_val/rt_val are the operands;
// is_branch flags a recognised conditional branch, taken its outcome.
// All magnitude compares are signed, done on the sign bit and a zero test.
module branch_cond_eval
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [5:0]      opcode,
  input  logic [4:0]      rt,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic            is_branch,
  output logic            taken
);

  logic rs_neg;
  logic rs_zero;

  assign rs_neg  = rs_val[XLEN-1];
  assign rs_zero = (rs_val == '0);

  always_comb begin
    is_branch = 1'b0;
    taken     = 1'b0;
    case (opcode)
      OP_BEQ: begin
        is_branch = 1'b1;
        taken     = (rs_val == rt_val);
      end
      OP_BNE: begin
        is_branch = 1'b1;
        taken     = (rs_val != rt_val);
      end
      OP_BLEZ: begin
        is_branch = 1'b1;
        taken     = rs_neg || rs_zero;
      end
      OP_BGTZ: begin
        is_branch = 1'b1;
        taken     = !rs_neg && !rs_zero;
      end
      OP_REGIMM: begin
        if (rt == RT_BLTZ) begin
          is_branch = 1'b1;
          taken     = rs_neg;
        end else if (rt == RT_BGEZ) begin
          is_branch = 1'b1;
          taken     = !rs_neg;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves MIPS conditional branches, computes the
// successor PC, trains a direct-mapped 2-bit predictor table and keeps
// saturating branch/mispredict statistics.
// Ports: clk, rst_n (async active-low), flush (kills held result, blocks
// accept), pred_pc/pred_taken (fetch-side table lookup), bus (req/res
// valid-ready handshake), stat_branches/stat_mispredicts.
module branch_resolve_unit
  import mips_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [XLEN-1:0]      pred_pc,
  output logic                 pred_taken,
  branch_resolve_unit_if.slave bus,
  output logic [CNT_W-1:0]     stat_branches,
  output logic [CNT_W-1:0]     stat_mispredicts
);

  localparam int ENTRIES = 2 ** IDX_W;

  bht_cnt_t        bht_q [ENTRIES];
  logic            res_valid_q;
  logic            res_is_branch_q;
  logic            res_taken_q;
  logic [XLEN-1:0] res_next_pc_q;
  logic            res_mispredict_q;
  logic [CNT_W-1:0] stat_br_q;
  logic [CNT_W-1:0] stat_mp_q;

  logic            accept;
  logic            is_branch;
  logic            taken;
  logic            mispredict;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] target_pc;
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] rd_idx;
  logic            unused_pred_pc_bits;

  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .opcode    (bus.req_opcode),
    .rt        (bus.req_rt),
    .rs_val    (bus.req_rs_val),
    .rt_val    (bus.req_rt_val),
    .is_branch (is_branch),
    .taken     (taken)
  );

  assign bus.req_ready = !flush && (!res_valid_q || bus.res_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  // Sums are XLEN wide, so the target wraps modulo 2^XLEN naturally.
  assign seq_pc     = bus.req_pc + XLEN'(4);
  assign target_pc  = seq_pc + {{(XLEN-18){bus.req_imm[15]}}, bus.req_imm, 2'b00};
  assign mispredict = taken ^ bus.req_pred_taken;

  assign upd_idx = bus.req_pc[IDX_W+1:2];
  assign rd_idx  = pred_pc[IDX_W+1:2];

  // Table read is from the registered array, so a same-cycle update is
  // not visible until the next cycle (read-before-write).
  assign pred_taken = bht_q[rd_idx][1];

  assign unused_pred_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= WNT;
    end else if (accept && is_branch) begin
      if (taken && bht_q[upd_idx] != ST)
        bht_q[upd_idx] <= bht_q[upd_idx] + 2'd1;
      else if (!taken && bht_q[upd_idx] != SNT)
        bht_q[upd_idx] <= bht_q[upd_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q      <= 1'b0;
      res_is_branch_q  <= 1'b0;
      res_taken_q      <= 1'b0;
      res_next_pc_q    <= '0;
      res_mispredict_q <= 1'b0;
    end else if (flush) begin
      res_valid_q <= 1'b0;
    end else if (accept) begin
      res_valid_q      <= 1'b1;
      res_is_branch_q  <= is_branch;
      res_taken_q      <= taken;
      res_next_pc_q    <= taken ? target_pc : seq_pc;
      res_mispredict_q <= mispredict;
    end else if (bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (accept && is_branch) begin
      if (stat_br_q != '1) stat_br_q <= stat_br_q + 1'b1;
      if (mispredict && stat_mp_q != '1) stat_mp_q <= stat_mp_q + 1'b1;
    end
  end

  assign bus.res_valid      = res_valid_q;
  assign bus.res_is_branch  = res_is_branch_q;
  assign bus.res_taken      = res_taken_q;
  assign bus.res_next_pc    = res_next_pc_q;
  assign bus.res_mispredict = res_mispredict_q;
  assign stat_branches      = stat_br_q;
  assign stat_mispredicts   = stat_mp_q;

endmodule
